// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

    typedef enum logic {
        PISO_IDLE,
        PISO_SHIFT
    } piso_state_t;

    function automatic int piso_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter tracking bits remaining in the current word.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = piso_cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] ld_val,
    output logic [CW-1:0] cnt,
    output logic          is_first,
    output logic          is_last
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = ld_val;
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign is_first = cnt_q == CW'(WIDTH);
    assign is_last  = cnt_q == CW'(1);

endmodule

// File: rtl/piso_serializer.sv
// Serializer with valid/ready load, one-deep hold buffer and
// selectable bit order; streams back-to-back words gap-free.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin,
    input  logic             pin_valid,
    output logic             pin_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = piso_cnt_w(WIDTH);

    piso_state_t      state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;

    logic [CW-1:0]    bits_left;
    logic             is_first;
    logic             is_last;
    logic             shifting;
    logic             accept;
    logic             out_bit;
    logic             cnt_load;
    logic [WIDTH-1:0] sreg_shifted;

    assign shifting     = rst && (state_q == PISO_SHIFT);
    assign pin_ready    = rst && !hold_full_q;
    assign accept       = pin_valid && pin_ready;
    assign out_bit      = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];
    assign sreg_shifted = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);

    assign sout        = shifting && out_bit;
    assign sout_valid  = shifting && shift_en;
    assign frame_start = sout_valid && is_first;
    assign frame_done  = sout_valid && is_last;
    // bits_left is nonzero exactly while a word is shifting
    assign busy        = rst && (bits_left != '0 || hold_full_q);

    assign cnt_load = (accept && !shifting)
                    || (frame_done && (hold_full_q || accept));

    piso_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (sout_valid),
        .ld_val   (CW'(WIDTH)),
        .cnt      (bits_left),
        .is_first (is_first),
        .is_last  (is_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= PISO_IDLE;
            sreg_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            unique case (state_q)
                PISO_IDLE: begin
                    if (accept) begin
                        sreg_q  <= pin;
                        state_q <= PISO_SHIFT;
                    end
                end
                PISO_SHIFT: begin
                    if (frame_done) begin
                        if (hold_full_q) begin
                            sreg_q      <= hold_q;
                            hold_full_q <= 1'b0;
                        end else if (accept) begin
                            sreg_q <= pin;
                        end else begin
                            sreg_q  <= sreg_shifted;
                            state_q <= PISO_IDLE;
                        end
                    end else begin
                        if (sout_valid) begin
                            sreg_q <= sreg_shifted;
                        end
                        if (accept) begin
                            hold_q      <= pin;
                            hold_full_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= PISO_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench: LSB-first and MSB-first serializers against a word-queue model.
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] pin;
    logic         pin_valid;
    logic         shift_en;

    logic rdy_l, sout_l, sv_l, fs_l, fd_l, busy_l;
    logic rdy_m, sout_m, sv_m, fs_m, fd_m, busy_m;

    int n_tests;
    int n_fail;

    logic [W-1:0] q[$];
    int           pos;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk         (clk),
        .rst         (rst),
        .pin         (pin),
        .pin_valid   (pin_valid),
        .pin_ready   (rdy_l),
        .shift_en    (shift_en),
        .sout        (sout_l),
        .sout_valid  (sv_l),
        .frame_start (fs_l),
        .frame_done  (fd_l),
        .busy        (busy_l)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk         (clk),
        .rst         (rst),
        .pin         (pin),
        .pin_valid   (pin_valid),
        .pin_ready   (rdy_m),
        .shift_en    (shift_en),
        .sout        (sout_m),
        .sout_valid  (sv_m),
        .frame_start (fs_m),
        .frame_done  (fd_m),
        .busy        (busy_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Check outputs mid-cycle, then advance model and clock by one cycle.
    task automatic step();
        logic         act;
        logic         ev;
        logic         acc;
        logic [W-1:0] w;
        #1;
        act = rst && q.size() > 0;
        ev  = act && shift_en;
        w   = act ? q[0] : '0;
        chk("ready_l", rdy_l, rst && q.size() < 2);
        chk("ready_m", rdy_m, rst && q.size() < 2);
        chk("busy_l", busy_l, act);
        chk("busy_m", busy_m, act);
        chk("svalid_l", sv_l, ev);
        chk("svalid_m", sv_m, ev);
        chk("sout_l", sout_l, act && w[pos]);
        chk("sout_m", sout_m, act && w[W-1-pos]);
        chk("fstart_l", fs_l, ev && pos == 0);
        chk("fstart_m", fs_m, ev && pos == 0);
        chk("fdone_l", fd_l, ev && pos == W-1);
        chk("fdone_m", fd_m, ev && pos == W-1);
        acc = pin_valid && rst && q.size() < 2;
        @(posedge clk);
        if (!rst) begin
            q.delete();
            pos = 0;
        end else begin
            if (ev) begin
                pos++;
                if (pos == W) begin
                    void'(q.pop_front());
                    pos = 0;
                end
            end
            if (acc) q.push_back(pin);
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [W-1:0] w);
        bit done;
        done = 1'b0;
        pin       = w;
        pin_valid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            done = rst && q.size() < 2;
            step();
        end
        pin_valid = 1'b0;
        chk("send_accepted", done, 1'b1);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        pos       = 0;
        rst       = 1'b0;
        pin       = 4'h5;
        pin_valid = 1'b1;
        shift_en  = 1'b1;
        @(negedge clk);

        run(2);
        rst       = 1'b1;
        pin_valid = 1'b0;
        run(1);

        send(4'b0101);
        run(6);

        send(4'b1100);
        run(6);

        send(4'hA);
        send(4'h3);
        run(10);

        send(4'b0110);
        run(2);
        shift_en = 1'b0;
        run(3);
        shift_en = 1'b1;
        run(4);

        send(4'h9);
        send(4'h6);
        run(2);
        rst = 1'b0;
        run(1);
        rst = 1'b1;
        run(2);
        send(4'hD);
        run(6);

        for (int i = 0; i < 400; i++) begin
            pin       = W'($urandom);
            pin_valid = ($urandom_range(0, 2) != 0);
            shift_en  = ($urandom_range(0, 4) != 0);
            rst       = ($urandom_range(0, 59) != 0);
            step();
        end
        rst       = 1'b1;
        pin_valid = 1'b0;
        shift_en  = 1'b1;
        run(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
